mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- M-stage data-memory access controller for the MIPS pipeline.
- Accepts one load/store per instruction and checks alignment and address range, raising AdEL or AdES on a violation.
- Drives a single-outstanding req/ack bus to DM and the timer devices, computing byte enables and replicating store data.
- Stalls the pipeline until the bus completes, then presents the raw read word and its low address bits to the load-extraction stage.

Parameters:
TIMEOUT, 16, cycles WAIT may last without bus_ack before the access aborts with an exception
DM_TOP, 32'h0000_2fff, last legal DM byte address (DM spans 0..DM_TOP)
TC0_BASE, 32'h0000_7f00, timer0 register base (12 bytes)
TC1_BASE, 32'h0000_7f10, timer1 register base (12 bytes)
INT_BASE, 32'h0000_7f20, interrupt-generator register (4 bytes)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  M-stage instruction holds a memory op
sel_ld  in  3  0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu
sel_st  in  2  0 none, 1 sw, 2 sh, 3 sb
addr  in  32  effective byte address
wdata  in  32  store data (rt)
ov  in  1  address-calculation overflow
flush  in  1  kill current M-stage op (exception/eret)
bus_req  out  1  bus request
bus_we  out  1  write strobe
bus_addr  out  32  word address {addr[31:2],2'b00}
bus_be  out  4  byte enables
bus_wdata  out  32  replicated store data
bus_ack  in  1  bus completion (one-cycle pulse)
bus_rdata  in  32  read word, valid with bus_ack
stall  out  1  freeze F/D/E/M
done  out  1  one-cycle access-complete pulse
rd_word  out  32  latched read word
addr10  out  2  latched addr[1:0] of the completed load
ld_sel_out  out  3  latched sel_ld of the completed load
exc_adel  out  1  load address error, one-cycle pulse
exc_ades  out  1  store address error, one-cycle pulse

Behaviour:
- Reset (async, immediate):
  - State → IDLE.
  - All outputs 0: bus_req, bus_we, bus_be, bus_addr, bus_wdata, stall, done, rd_word, addr10, ld_sel_out, exc_*.
  - Timeout counter and kill flag cleared.
  - Reset mid-transaction abandons the access; no pulse is emitted.
- sel_ld and sel_st both nonzero is illegal; store takes priority.
- Exception check, combinational, in IDLE:
  - Misalignment: lw/sw need addr[1:0]==0; lh/lhu/sh need addr[0]==0.
  - ov set.
  - Address outside DM, TC0 (+0..+11), TC1 (+0..+11) or INT (+0..+3).
  - Sub-word (h/b) access to TC0 or TC1.
  - Store to a timer count register (TCx_BASE+8..+11).
- Exception response: no bus request. exc_adel (load) or exc_ades (store) pulses in the cycle after acceptance; stall stays 0.
- States:
  - IDLE → WAIT when req_valid & op & !exc & !flush. Bus outputs register at this edge; bus_req=1 from the next cycle.
  - WAIT: bus outputs stay stable until bus_ack. On ack: rd_word←bus_rdata, addr10 and ld_sel_out latched, → DONE.
  - WAIT, counter reaches TIMEOUT with no ack: bus_req drops, exc_adel/exc_ades flagged, → DONE.
  - DONE: one cycle. done=1 (or the exc pulse instead on timeout). bus_req=0. → IDLE.
- stall = (req_valid & op & !exc & !flush & state==IDLE) | state==WAIT. Stall is 0 in DONE, so the pipeline advances exactly once per access.
- Minimum latency: issue edge + 1 WAIT cycle + DONE = 3 cycles with ack on the first WAIT cycle.
- Byte enables:
  - Loads and sw: 1111.
  - sh: addr[1] ? 1100 : 0011.
  - sb: 0001 << addr[1:0].
- Store data:
  - sh: {2{wdata[15:0]}}.
  - sb: {4{wdata[7:0]}}.
  - sw: wdata.
- bus_we=1 for stores only.
- flush handling:
  - flush in IDLE: nothing issues.
  - flush in WAIT: the kill flag is set. The transaction runs to ack or timeout because the bus cannot be cancelled, and stall stays 1 meanwhile. DONE then emits no done and no exc.
  - flush in DONE is ignored.
- bus_ack outside WAIT is ignored.
- The timeout counter clears on entry to WAIT.

Test Plan:
- lw addr=0x0000_1004, ack on 2nd WAIT cycle, rdata=0xDEADBEEF → bus_be=1111, bus_we=0; stall high 3 cycles; done pulse; rd_word=0xDEADBEEF, addr10=00, ld_sel_out=1.
- sb addr=0x0000_0013, wdata=0x0000_00A5 → bus_addr=0x0000_0010, bus_be=1000, bus_wdata=0xA5A5A5A5, bus_we=1; done after ack.
- lh addr=0x0000_0001 → no bus_req; exc_adel pulses one cycle; stall=0. Also: sw to 0x7f08 → exc_ades. lb at 0x7f04 → exc_adel. lw at 0x0000_3000 → exc_adel.
- sw addr=0x0000_0020 with bus_ack withheld → bus_req holds 16 WAIT cycles, then drops; exc_ades pulses; pipeline resumes.
- lw issued, flush asserted in first WAIT cycle, ack 3 cycles later → stall held until ack; no done, no exc; next op issues normally.
- reset asserted mid-WAIT → bus_req and stall drop immediately; after release a new lbu at 0x0000_0002 completes with addr10=10, ld_sel_out=5.

Source files
------------

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : M-stage data-memory access controller. Checks alignment and
//            address range, issues one req/ack bus transaction at a time,
//            stalls the pipeline until completion and hands the raw read
//            word to the load-extraction stage.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] DM_TOP   = 32'h0000_2fff,
    parameter logic [31:0] TC0_BASE = 32'h0000_7f00,
    parameter logic [31:0] TC1_BASE = 32'h0000_7f10,
    parameter logic [31:0] INT_BASE = 32'h0000_7f20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  sel_ld,
    input  logic [1:0]  sel_st,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        ov,
    input  logic        flush,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rd_word,
    output logic [1:0]  addr10,
    output logic [2:0]  ld_sel_out,
    output logic        exc_adel,
    output logic        exc_ades
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_kill;
    logic [2:0]          r_ld_sel;
    logic [1:0]          r_addr_lo;

    logic        w_is_store;
    logic        w_is_load;
    logic        w_op;
    logic        w_word;
    logic        w_half;
    logic        w_in_dm;
    logic        w_in_tc0;
    logic        w_in_tc1;
    logic        w_in_int;
    logic        w_tc_cnt;
    logic        w_exc;
    logic        w_accept;
    logic        w_exc_hit;
    logic        w_kill;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wd;
    logic [2:0]  w_ld_sel;

    // Decode the op, classify the address and build the exception condition.
    always_comb begin
        w_is_store = (sel_st != 2'd0);
        w_is_load  = !w_is_store && (sel_ld >= 3'd1) && (sel_ld <= 3'd5);
        w_op       = w_is_store || w_is_load;
        w_word     = w_is_store ? (sel_st == 2'd1) : (sel_ld == 3'd1);
        w_half     = w_is_store ? (sel_st == 2'd2) : ((sel_ld == 3'd2) || (sel_ld == 3'd3));
        w_ld_sel   = w_is_load ? sel_ld : 3'd0;

        w_in_dm  = (addr <= DM_TOP);
        w_in_tc0 = (addr >= TC0_BASE) && (addr <= TC0_BASE + 32'd11);
        w_in_tc1 = (addr >= TC1_BASE) && (addr <= TC1_BASE + 32'd11);
        w_in_int = (addr >= INT_BASE) && (addr <= INT_BASE + 32'd3);
        // Count registers sit at +8..+11 of each timer and are read-only.
        w_tc_cnt = ((addr >= TC0_BASE + 32'd8) && (addr <= TC0_BASE + 32'd11)) ||
                   ((addr >= TC1_BASE + 32'd8) && (addr <= TC1_BASE + 32'd11));

        w_exc = (w_word && (addr[1:0] != 2'b00))
              || (w_half && addr[0])
              || ov
              || !(w_in_dm || w_in_tc0 || w_in_tc1 || w_in_int)
              || (!w_word && (w_in_tc0 || w_in_tc1))
              || (w_is_store && w_tc_cnt);

        w_accept  = (r_state == S_IDLE) && req_valid && w_op && !w_exc && !flush;
        w_exc_hit = (r_state == S_IDLE) && req_valid && w_op &&  w_exc && !flush;
        // A flush in the same cycle as the ack still suppresses the pulse.
        w_kill    = r_kill || flush;
    end

    // Byte enables and lane-replicated store data for the issued access.
    always_comb begin
        w_be = 4'b1111;
        w_wd = 32'h0;
        case (sel_st)
            2'd1: w_wd = wdata;
            2'd2: begin
                w_be = addr[1] ? 4'b1100 : 4'b0011;
                w_wd = {2{wdata[15:0]}};
            end
            2'd3: begin
                w_be = 4'b0001 << addr[1:0];
                w_wd = {4{wdata[7:0]}};
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic, timeout detection and pipeline stall.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        stall     = (w_accept && !reset) || (r_state == S_WAIT);
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_WAIT;
            S_WAIT: begin
                if (bus_ack) begin
                    w_next = S_DONE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Bus drive, completion latching, timeout counter and one-cycle pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'h0;
            bus_be     <= 4'h0;
            bus_wdata  <= 32'h0;
            done       <= 1'b0;
            rd_word    <= 32'h0;
            addr10     <= 2'b00;
            ld_sel_out <= 3'd0;
            exc_adel   <= 1'b0;
            exc_ades   <= 1'b0;
            r_cnt      <= '0;
            r_kill     <= 1'b0;
            r_ld_sel   <= 3'd0;
            r_addr_lo  <= 2'b00;
        end else begin
            done     <= 1'b0;
            exc_adel <= 1'b0;
            exc_ades <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    bus_req   <= 1'b1;
                    bus_we    <= w_is_store;
                    bus_addr  <= {addr[31:2], 2'b00};
                    bus_be    <= w_be;
                    bus_wdata <= w_wd;
                    r_ld_sel  <= w_ld_sel;
                    r_addr_lo <= addr[1:0];
                    r_cnt     <= '0;
                    r_kill    <= 1'b0;
                end else if (w_exc_hit) begin
                    exc_adel <= !w_is_store;
                    exc_ades <= w_is_store;
                end
            end else if (r_state == S_WAIT) begin
                if (flush) r_kill <= 1'b1;
                if (bus_ack) begin
                    bus_req    <= 1'b0;
                    rd_word    <= bus_rdata;
                    addr10     <= r_addr_lo;
                    ld_sel_out <= r_ld_sel;
                    done       <= !w_kill;
                end else if (w_timeout) begin
                    bus_req  <= 1'b0;
                    exc_adel <= !bus_we && !w_kill;
                    exc_ades <=  bus_we && !w_kill;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
